// File: rtl/key_debounce_ctrl_pkg.sv
// Shared types for the key debounce controller.
package key_debounce_ctrl_pkg;

  // Debounce FSM states. The encodings are fixed so that they line up with the other blocks.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_P  = 2'd1,
    ST_PRESSED = 2'd2,
    ST_WAIT_R  = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce_ctrl_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit. The reset value is a parameter.
module key_debounce_ctrl_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The metastable first stage feeds the second stage. Only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce_ctrl.sv
// Push-button debounce front-end. It synchronises the key, asks delay_10ms for a
// settle wait, and confirms the press or release when dly_over returns.
module key_debounce_ctrl #(
  parameter logic KEY_ACTIVE = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  input  logic             dly_over,
  output logic             dly_sig,
  output logic             key_state,
  output logic             key_press,
  output logic             key_release,
  output logic [CNT_W-1:0] press_cnt
);
  import key_debounce_ctrl_pkg::*;

  logic             key_sync;
  logic             key_s;
  state_e           state_q,       state_d;
  logic             dly_sig_q,     dly_sig_d;
  logic             key_state_q,   key_state_d;
  logic             key_press_q,   key_press_d;
  logic             key_release_q, key_release_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;

  // The synchroniser resets to the released level so that reset never looks like a press.
  key_debounce_ctrl_sync_2ff #(.RST_VAL(~KEY_ACTIVE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (key_in),
    .q_o   (key_sync)
  );

  assign key_s = (key_sync == KEY_ACTIVE);

  // Next-state and registered-output logic. Every strobe defaults low, so each one lasts a single cycle.
  always_comb begin
    state_d       = state_q;
    dly_sig_d     = 1'b0;
    key_state_d   = key_state_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    cnt_d         = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_s) begin
          dly_sig_d = 1'b1;
          state_d   = ST_WAIT_P;
        end
      end
      ST_WAIT_P: begin
        // The key level is not looked at until the settle wait ends.
        if (dly_over) begin
          if (key_s) begin
            state_d     = ST_PRESSED;
            key_state_d = 1'b1;
            key_press_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PRESSED: begin
        if (!key_s) begin
          dly_sig_d = 1'b1;
          state_d   = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (dly_over) begin
          if (!key_s) begin
            state_d       = ST_IDLE;
            key_state_d   = 1'b0;
            key_release_d = 1'b1;
          end else begin
            state_d = ST_PRESSED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. An async reset drops back to IDLE even in the middle of a wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dly_sig_q     <= 1'b0;
      key_state_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      dly_sig_q     <= dly_sig_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      cnt_q         <= cnt_d;
    end
  end

  assign dly_sig     = dly_sig_q;
  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign press_cnt   = cnt_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Scoreboard bench for key_debounce_ctrl. Stimulus queues the expected strobe events,
// and a negedge monitor pops and compares them as the DUT raises strobes.
module tb_key_debounce_ctrl;

  localparam int T10MS = 20;
  localparam logic [2:0] EV_DS = 3'b100;
  localparam logic [2:0] EV_KP = 3'b010;
  localparam logic [2:0] EV_KR = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic       ks;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       dly_over;
  logic       dly_sig;
  logic       key_state;
  logic       key_press;
  logic       key_release;
  logic [7:0] press_cnt;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;
  int         presses = 0;
  ev_t        sb[$];

  key_debounce_ctrl #(.KEY_ACTIVE(1'b0), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .dly_over    (dly_over),
    .dly_sig     (dly_sig),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .press_cnt   (press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] kind, input int c, input logic ks, input logic [7:0] cnt);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ks = ks; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic pulse_over();
    dly_over = 1'b1;
    step(1);
    dly_over = 1'b0;
  endtask

  // Clean press: dly_sig 3 cycles after the pin edge, key_press 1 cycle after dly_over.
  task automatic press_clean();
    key_in = 1'b0;
    push(EV_DS, cyc + 3, 1'b0, exp_cnt);
    step(3 + T10MS);
    exp_cnt = exp_cnt + 8'd1;
    presses++;
    push(EV_KP, cyc + 1, 1'b1, exp_cnt);
    pulse_over();
    step(2);
  endtask

  task automatic release_clean();
    key_in = 1'b1;
    push(EV_DS, cyc + 3, 1'b1, exp_cnt);
    step(3 + T10MS);
    push(EV_KR, cyc + 1, 1'b0, exp_cnt);
    pulse_over();
    step(2);
  endtask

  // Monitor: every strobe has to match the head of the scoreboard.
  always @(negedge clk) begin
    if (dly_sig || key_press || key_release) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", int'({dly_sig, key_press, key_release}), 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_kind", int'({dly_sig, key_press, key_release}), int'(e.kind));
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_key_state", int'(key_state), int'(e.ks));
        chk("ev_press_cnt", int'(press_cnt), int'(e.cnt));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    key_in   = 1'b1;
    dly_over = 1'b0;
    step(3);
    chk("rst_dly_sig", int'(dly_sig), 0);
    chk("rst_key_state", int'(key_state), 0);
    chk("rst_key_press", int'(key_press), 0);
    chk("rst_key_release", int'(key_release), 0);
    chk("rst_press_cnt", int'(press_cnt), 0);
    rst_n = 1'b1;
    step(3);

    // Bounce reject: the key is low for 5 cycles and released before dly_over.
    key_in = 1'b0;
    push(EV_DS, cyc + 3, 1'b0, exp_cnt);
    step(5);
    key_in = 1'b1;
    step(15);
    pulse_over();
    step(3);
    chk("bounce_key_state", int'(key_state), 0);
    chk("bounce_press_cnt", int'(press_cnt), 0);

    // Clean press.
    press_clean();
    chk("press_key_state", int'(key_state), 1);
    chk("press_cnt_1", int'(press_cnt), 1);

    // Release that bounces back to pressed before dly_over.
    key_in = 1'b1;
    push(EV_DS, cyc + 3, 1'b1, exp_cnt);
    step(8);
    key_in = 1'b0;
    step(5);
    pulse_over();
    step(3);
    chk("rel_bounce_key_state", int'(key_state), 1);

    // Clean release.
    release_clean();
    chk("release_key_state", int'(key_state), 0);

    // Spurious dly_over in IDLE and in PRESSED.
    pulse_over();
    step(3);
    chk("spur_idle_key_state", int'(key_state), 0);
    chk("spur_idle_cnt", int'(press_cnt), 1);
    press_clean();
    pulse_over();
    step(3);
    chk("spur_pressed_key_state", int'(key_state), 1);
    chk("spur_pressed_cnt", int'(press_cnt), 2);
    release_clean();

    // Counter wrap: 256 presses return to 0, and the 257th gives 1.
    while (presses < 257) begin
      press_clean();
      if (presses == 256) chk("wrap_cnt_256", int'(press_cnt), 0);
      release_clean();
    end
    chk("wrap_cnt_257", int'(press_cnt), 1);

    // Async reset in the middle of WAIT_P, with the key kept held afterwards.
    key_in = 1'b0;
    push(EV_DS, cyc + 3, 1'b0, exp_cnt);
    step(8);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dly_sig", int'(dly_sig), 0);
    chk("arst_key_state", int'(key_state), 0);
    chk("arst_press_cnt", int'(press_cnt), 0);
    exp_cnt = 8'd0;
    step(2);
    rst_n = 1'b1;
    press_clean();
    chk("post_rst_cnt", int'(press_cnt), 1);
    release_clean();

    step(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
